// File: rtl/stall_flush_controller_pkg.sv
// ============================================================================
// Module   : nand_cpu (package)
// Brief    : Shared types for the pipeline stall/flush controller: controller
//            FSM states, the shadow destination tag and a tag helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef PC_SIZE
`define PC_SIZE 16
`endif

package nand_cpu;

  // Destination field wide enough for any register file up to 256 entries;
  // narrower register tags are zero-extended into it.
  localparam int TAG_DST_W = 8;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_STALL   = 2'd1,
    ST_TIMEOUT = 2'd2
  } sfc_state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_DST_W-1:0] dst;
  } reg_tag_t;

  function automatic reg_tag_t make_tag(input logic valid, input logic [TAG_DST_W-1:0] dst);
    reg_tag_t t;
    t.valid = valid;
    t.dst   = dst;
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stall_flush_controller_if.sv
// ============================================================================
// Module   : stall_flush_controller_if
// Brief    : Bundle of branch feedback, predictor redirect, decode operands,
//            busy input and the per-register hold/bubble controls.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef PC_SIZE
`define PC_SIZE 16
`endif

interface stall_flush_controller_if #(
  parameter int NUM_STAGES = 4,
  parameter int RW         = 4
);
  // Branch feedback from the resolve stage
  logic                  fb_valid;
  logic                  fb_predict_taken;
  logic                  fb_feedback_taken;
  logic [`PC_SIZE-1:0]   fb_predict_target;
  logic [`PC_SIZE-1:0]   fb_feedback_target;
  logic [`PC_SIZE-1:0]   fb_pc;
  // Branch predictor redirect
  logic                  bp_pc_override;
  logic [`PC_SIZE-1:0]   bp_target;
  // Decode-stage operands
  logic                  dec_valid;
  logic                  dec_writes;
  logic [RW-1:0]         dec_dst;
  logic [RW-1:0]         dec_src_a;
  logic [RW-1:0]         dec_src_b;
  // Long-latency unit at the last register
  logic                  busy;
  // Controls back to the pipeline and fetch
  logic [NUM_STAGES-1:0] retain;
  logic [NUM_STAGES-1:0] clear;
  logic                  fetch_stall;
  logic                  pc_override;
  logic [`PC_SIZE-1:0]   target;
  logic                  stall_timeout;

  modport master (
    output fb_valid, fb_predict_taken, fb_feedback_taken,
    output fb_predict_target, fb_feedback_target, fb_pc,
    output bp_pc_override, bp_target,
    output dec_valid, dec_writes, dec_dst, dec_src_a, dec_src_b,
    output busy,
    input  retain, clear, fetch_stall, pc_override, target, stall_timeout
  );

  modport slave (
    input  fb_valid, fb_predict_taken, fb_feedback_taken,
    input  fb_predict_target, fb_feedback_target, fb_pc,
    input  bp_pc_override, bp_target,
    input  dec_valid, dec_writes, dec_dst, dec_src_a, dec_src_b,
    input  busy,
    output retain, clear, fetch_stall, pc_override, target, stall_timeout
  );

endinterface

`default_nettype wire

// File: rtl/stall_flush_controller_hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : Shadow destination tags that travel alongside pipeline
//            registers 1..NUM_STAGES-1, plus the decode RAW comparison.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard
  import nand_cpu::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int RW         = 4
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic [NUM_STAGES-1:1] retain,
  input  wire logic [NUM_STAGES-1:1] clear,
  input  wire logic                  dec_valid,
  input  wire logic                  dec_writes,
  input  wire logic [RW-1:0]         dec_dst,
  input  wire logic [RW-1:0]         dec_src_a,
  input  wire logic [RW-1:0]         dec_src_b,
  output logic                       raw_hazard
);

  reg_tag_t [NUM_STAGES-1:1] r_tag;
  reg_tag_t [NUM_STAGES-1:1] w_src;
  logic     [NUM_STAGES-1:1] w_hit;

  // Register 1 captures the instruction currently in decode; every later
  // register inherits its predecessor's tag. Register 0 of the file is an
  // ordinary register, so no index is exempt from matching.
  for (genvar k = 1; k < NUM_STAGES; k++) begin : g_stage
    if (k == 1) begin : g_first
      assign w_src[k] = make_tag(dec_valid & dec_writes, TAG_DST_W'(dec_dst));
    end else begin : g_chain
      assign w_src[k] = r_tag[k-1];
    end
    assign w_hit[k] = r_tag[k].valid &
                      ((r_tag[k].dst == TAG_DST_W'(dec_src_a)) |
                       (r_tag[k].dst == TAG_DST_W'(dec_src_b)));
  end

  // Shadow tags hold, drop to a bubble, or advance with their register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag <= '0;
    end else begin
      for (int k = 1; k < NUM_STAGES; k++) begin
        if (retain[k]) begin
          r_tag[k] <= r_tag[k];
        end else if (clear[k]) begin
          r_tag[k] <= '0;
        end else begin
          r_tag[k] <= w_src[k];
        end
      end
    end
  end

  assign raw_hazard = dec_valid & (|w_hit);

endmodule

`default_nettype wire

// File: rtl/stall_flush_controller.sv
// ============================================================================
// Module   : stall_flush_controller
// Brief    : Pipeline hold/flush control: busy and RAW stalls, branch
//            mispredict flush and redirect, and a sticky stall watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef PC_SIZE
`define PC_SIZE 16
`endif

module stall_flush_controller
  import nand_cpu::*;
#(
  parameter int NUM_STAGES    = 4,
  parameter int RESOLVE_STAGE = 2,
  parameter int NUM_REGS      = 16,
  parameter int MAX_STALL     = 15
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  stall_flush_controller_if.slave bus
);

  localparam int RW = $clog2(NUM_REGS);
  localparam int CW = $clog2(MAX_STALL + 1);
  // Registers ahead of the resolve point hold wrong-path work on a mispredict.
  localparam logic [NUM_STAGES-1:0] RESOLVE_MASK = NUM_STAGES'((1 << RESOLVE_STAGE) - 1);
  localparam logic [CW-1:0]         STALL_LIMIT  = CW'(MAX_STALL);

  sfc_state_t            r_state;
  sfc_state_t            w_state_next;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_next;

  logic                  w_raw;
  logic                  w_mismatch;
  logic [NUM_STAGES-1:0] w_retain;
  logic [NUM_STAGES-1:0] w_clear;
  logic                  w_fetch_stall;
  logic                  w_pc_override;
  logic [`PC_SIZE-1:0]   w_target;

  hazard_scoreboard #(
    .NUM_STAGES (NUM_STAGES),
    .RW         (RW)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .retain     (w_retain[NUM_STAGES-1:1]),
    .clear      (w_clear[NUM_STAGES-1:1]),
    .dec_valid  (bus.dec_valid),
    .dec_writes (bus.dec_writes),
    .dec_dst    (bus.dec_dst),
    .dec_src_a  (bus.dec_src_a),
    .dec_src_b  (bus.dec_src_b),
    .raw_hazard (w_raw)
  );

  // Wrong direction, or taken to the wrong place.
  assign w_mismatch = bus.fb_valid &
                      ((bus.fb_predict_taken != bus.fb_feedback_taken) |
                       (bus.fb_feedback_taken &
                        (bus.fb_predict_target != bus.fb_feedback_target)));

  // Pipeline controls. Busy freezes everything including the resolve
  // register, so its feedback is only acted on once busy drops; a
  // mispredict outranks a RAW stall because the stalled decode is flushed.
  always_comb begin
    w_retain      = '0;
    w_clear       = '0;
    w_fetch_stall = 1'b0;
    w_pc_override = 1'b0;
    w_target      = bus.bp_target;
    if (r_state == ST_TIMEOUT) begin
      w_retain      = '1;
      w_fetch_stall = 1'b1;
    end else if (bus.busy) begin
      w_retain      = '1;
      w_fetch_stall = 1'b1;
    end else if (w_mismatch) begin
      w_clear       = RESOLVE_MASK;
      w_pc_override = 1'b1;
      w_target      = bus.fb_feedback_taken ? bus.fb_feedback_target
                                            : bus.fb_pc + `PC_SIZE'(1);
    end else if (w_raw) begin
      w_retain[0]   = 1'b1;
      w_clear[1]    = 1'b1;
      w_fetch_stall = 1'b1;
    end else begin
      w_pc_override = bus.bp_pc_override;
    end
  end

  // Consecutive stalled-cycle count, saturating at the watchdog limit.
  always_comb begin
    w_cnt_next = '0;
    if (w_fetch_stall) begin
      w_cnt_next = (r_cnt >= STALL_LIMIT) ? r_cnt : r_cnt + CW'(1);
    end
  end

  // Watchdog FSM next state; TIMEOUT is left only through reset.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN, ST_STALL: begin
        if (w_fetch_stall) begin
          w_state_next = (w_cnt_next >= STALL_LIMIT) ? ST_TIMEOUT : ST_STALL;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_TIMEOUT: w_state_next = ST_TIMEOUT;
      default:    w_state_next = ST_RUN;
    endcase
  end

  // State and stall counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  assign bus.retain        = w_retain;
  assign bus.clear         = w_clear;
  assign bus.fetch_stall   = w_fetch_stall;
  assign bus.pc_override   = w_pc_override;
  assign bus.target        = w_target;
  assign bus.stall_timeout = (r_state == ST_TIMEOUT);

endmodule

`default_nettype wire

// File: tb/tb_stall_flush_controller.sv
// ============================================================================
// Module   : tb_stall_flush_controller
// Brief    : Scoreboard bench for stall_flush_controller: directed scenarios
//            followed by random traffic against a behavioural pipeline model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef PC_SIZE
`define PC_SIZE 16
`endif

module tb_stall_flush_controller;

  localparam int NS = 4;
  localparam int RS = 2;
  localparam int NR = 16;
  localparam int MS = 15;
  localparam int RW = 4;
  localparam int PW = `PC_SIZE;

  typedef struct packed {
    logic [NS-1:0] retain;
    logic [NS-1:0] clear;
    logic          fs;
    logic          po;
    logic [PW-1:0] target;
    logic          to;
  } exp_t;

  typedef struct {
    bit            rst;
    bit            fbv, pt, ft;
    logic [PW-1:0] ptgt, ftgt, pc;
    bit            bpo;
    logic [PW-1:0] bpt;
    bit            dv, dw;
    logic [RW-1:0] dd, sa, sb;
    bit            busy;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stall_flush_controller_if #(.NUM_STAGES(NS), .RW(RW)) bus ();

  stall_flush_controller #(
    .NUM_STAGES    (NS),
    .RESOLVE_STAGE (RS),
    .NUM_REGS      (NR),
    .MAX_STALL     (MS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- reference model: what each pipeline slot holds --------
  bit            m_wr  [1:NS-1];   // instruction in slot k writes a register
  logic [RW-1:0] m_reg [1:NS-1];   // ... and which one
  int            m_stalls;          // consecutive stalled cycles
  bit            m_dead;            // watchdog fired

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  function automatic void model_reset();
    for (int k = 1; k < NS; k++) begin
      m_wr[k]  = 1'b0;
      m_reg[k] = '0;
    end
    m_stalls = 0;
    m_dead   = 1'b0;
  endfunction

  function automatic exp_t model_out(input stim_t s);
    exp_t e;
    bit   pending_write = 1'b0;
    bit   wrong_path;
    for (int k = 1; k < NS; k++)
      if (m_wr[k] && (m_reg[k] == s.sa || m_reg[k] == s.sb)) pending_write = 1'b1;
    wrong_path = s.fbv && ((s.pt != s.ft) || (s.ft && s.ptgt != s.ftgt));
    e        = '0;
    e.target = s.bpt;
    e.to     = m_dead;
    if (m_dead || s.busy) begin
      e.retain = '1;
      e.fs     = 1'b1;
    end else if (wrong_path) begin
      e.clear  = NS'((1 << RS) - 1);
      e.po     = 1'b1;
      e.target = s.ft ? s.ftgt : PW'(s.pc + 1);
    end else if (s.dv && pending_write) begin
      e.retain = NS'(1);
      e.clear  = NS'(2);
      e.fs     = 1'b1;
    end else begin
      e.po = s.bpo;
    end
    return e;
  endfunction

  function automatic void model_step(input stim_t s, input exp_t e);
    for (int k = NS - 1; k >= 1; k--) begin
      if (e.retain[k]) continue;
      if (e.clear[k]) begin
        m_wr[k] = 1'b0;
      end else if (k == 1) begin
        m_wr[1]  = s.dv && s.dw;
        m_reg[1] = s.dd;
      end else begin
        m_wr[k]  = m_wr[k-1];
        m_reg[k] = m_reg[k-1];
      end
    end
    if (e.fs) begin
      m_stalls++;
      if (m_stalls >= MS) m_dead = 1'b1;
    end else begin
      m_stalls = 0;
    end
  endfunction

  // ---------------- driver ----------------
  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.fbv = 0; s.pt = 0; s.ft = 0;
    s.ptgt = '0; s.ftgt = '0; s.pc = '0;
    s.bpo = 0; s.bpt = '0; s.dv = 0; s.dw = 0;
    s.dd = '0; s.sa = '0; s.sb = '0; s.busy = 0;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s = idle();
    if ($urandom_range(0, 99) == 0 || (m_dead && $urandom_range(0, 7) == 0)) begin
      s.rst = 1;
      return s;
    end
    s.busy = ($urandom_range(0, 19) == 0);
    s.fbv  = ($urandom_range(0, 3) == 0);
    s.pt   = $urandom_range(0, 1);
    s.ft   = $urandom_range(0, 1);
    s.ptgt = $urandom_range(0, 1) ? PW'(16'h0020) : PW'(16'h0030);
    s.ftgt = $urandom_range(0, 1) ? PW'(16'h0020) : PW'(16'h0030);
    s.pc   = ($urandom_range(0, 3) == 0) ? '1 : PW'($urandom);
    s.bpo  = $urandom_range(0, 1);
    s.bpt  = PW'($urandom);
    s.dv   = ($urandom_range(0, 3) != 0);
    s.dw   = $urandom_range(0, 1);
    s.dd   = RW'($urandom_range(0, 4));
    s.sa   = RW'($urandom_range(0, 4));
    s.sb   = RW'($urandom_range(0, 4));
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    rst_n                  = ~s.rst;
    bus.fb_valid           = s.fbv;
    bus.fb_predict_taken   = s.pt;
    bus.fb_feedback_taken  = s.ft;
    bus.fb_predict_target  = s.ptgt;
    bus.fb_feedback_target = s.ftgt;
    bus.fb_pc              = s.pc;
    bus.bp_pc_override     = s.bpo;
    bus.bp_target          = s.bpt;
    bus.dec_valid          = s.dv;
    bus.dec_writes         = s.dw;
    bus.dec_dst            = s.dd;
    bus.dec_src_a          = s.sa;
    bus.dec_src_b          = s.sb;
    bus.busy               = s.busy;
    if (s.rst) model_reset();
    e = model_out(s);
    q.push_back(e);
    if (!s.rst) model_step(s, e);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  exp_t mon_exp;
  exp_t mon_act;
  always @(negedge clk) begin
    cyc++;
    if (q.size() > 0) begin
      mon_exp = q.pop_front();
      mon_act = {bus.retain, bus.clear, bus.fetch_stall, bus.pc_override,
                 bus.target, bus.stall_timeout};
      n_checks++;
      if (mon_act === mon_exp) begin
        n_pass++;
      end else begin
        $display("FAIL outputs@cycle%0d: got retain=%b clear=%b fs=%b po=%b target=%h to=%b, want retain=%b clear=%b fs=%b po=%b target=%h to=%b",
                 cyc, mon_act.retain, mon_act.clear, mon_act.fs, mon_act.po, mon_act.target, mon_act.to,
                 mon_exp.retain, mon_exp.clear, mon_exp.fs, mon_exp.po, mon_exp.target, mon_exp.to);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    model_reset();
    s = idle();
    s.rst = 1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;

    // Reset, then idle
    repeat (2) step(s);
    s = idle();
    repeat (3) step(s);

    // Write r3, then a reader of r3 waits until the tag leaves register 3
    s = idle(); s.dv = 1; s.dw = 1; s.dd = 4'd3; s.sa = 4'd7; s.sb = 4'd8;
    step(s);
    s = idle(); s.dv = 1; s.sa = 4'd3; s.sb = 4'd9;
    repeat (5) step(s);

    // Not-taken mispredict at pc 0x10 -> redirect to 0x11
    s = idle(); s.fbv = 1; s.pt = 1; s.ft = 0; s.ptgt = 16'h0050; s.pc = 16'h0010;
    step(s);
    s = idle();
    step(s);

    // RAW stall and taken mispredict in the same cycle
    s = idle(); s.dv = 1; s.dw = 1; s.dd = 4'd5;
    step(s);
    s = idle(); s.dv = 1; s.sa = 4'd5; s.fbv = 1; s.pt = 0; s.ft = 1; s.ftgt = 16'h0040;
    step(s);
    s = idle();
    repeat (4) step(s);

    // Busy for MAX_STALL cycles -> sticky timeout, cleared by reset
    s = idle(); s.busy = 1; s.bpo = 1; s.bpt = 16'h1234;
    repeat (MS) step(s);
    s = idle(); s.bpo = 1; s.fbv = 1; s.pt = 1; s.pc = 16'h0100;
    repeat (3) step(s);
    s = idle(); s.rst = 1;
    step(s);
    s = idle();
    repeat (2) step(s);

    // Mispredict held while busy -> redirect only after busy falls
    s = idle(); s.busy = 1; s.fbv = 1; s.pt = 0; s.ft = 1; s.ftgt = 16'h0077;
    repeat (3) step(s);
    s.busy = 0;
    step(s);
    s = idle();
    repeat (2) step(s);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      s = rand_stim();
      step(s);
    end

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stall_flush_controller.md
STALL_FLUSH_CONTROLLER -- requirements
Module: stall_flush_controller

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4: number of pipeline registers; register 0 feeds decode, register NUM_STAGES-1 feeds writeback.
REQ-002 SHALL have parameter RESOLVE_STAGE, default 2: branches resolve on the output of register RESOLVE_STAGE-1; legal range 1..NUM_STAGES-1.
REQ-003 SHALL have parameter NUM_REGS, default 16; tag width RW = $clog2(NUM_REGS).
REQ-004 SHALL have parameter MAX_STALL, default 15: stall cycles allowed before timeout.
REQ-005 Ports:
- clk  in  1  clock; one clock domain, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fb_valid, fb_predict_taken, fb_feedback_taken  in  1 each  branch feedback.
- fb_predict_target, fb_feedback_target, fb_pc  in  `PC_SIZE each.
- bp_pc_override  in  1; bp_target  in  `PC_SIZE  predictor redirect.
- dec_valid, dec_writes  in  1 each; dec_dst, dec_src_a, dec_src_b  in  RW each  decode-stage operands.
- busy  in  1  long-latency unit on the output of register NUM_STAGES-1 not done.
- retain, clear  out  NUM_STAGES  per-register hold / load-bubble.
- fetch_stall  out  1; pc_override  out  1; target  out  `PC_SIZE.
- stall_timeout  out  1  sticky watchdog error.

Function
REQ-006 SHALL keep a shadow tag per register k=1..NUM_STAGES-1: {valid, dst}; it moves with the pipeline: held when retain[k], zeroed when clear[k], else loaded from k-1 (k=1 loads {dec_valid&dec_writes, dec_dst}).
REQ-007 RAW hazard = dec_valid and dec_src_a or dec_src_b equals a valid shadow dst in registers 1..NUM_STAGES-1; combinational, same cycle.
REQ-008 Busy stall: busy=1 -> retain[all]=1, fetch_stall=1, no clears except from REQ-010.
REQ-009 RAW stall without busy: retain[0]=1, clear[1]=1, fetch_stall=1, registers >=2 advance.
REQ-010 Mispredict = fb_valid & not retain[RESOLVE_STAGE-1] & (predict_taken != feedback_taken | (feedback_taken & predict_target != feedback_target)).
REQ-011 On mispredict: clear[k]=1 for k<RESOLVE_STAGE, retain[k]=0 for those k, fetch_stall=0, pc_override=1, target = feedback_taken ? fb_feedback_target : fb_pc+1 (modulo 2^`PC_SIZE).
REQ-012 Mispredict overrides a RAW stall the same cycle; a busy stall suppresses mispredict (feedback re-evaluated once released).
REQ-013 Without mispredict: pc_override=bp_pc_override & ~fetch_stall, target=bp_target.
REQ-014 FSM states RUN, STALL, TIMEOUT: RUN->STALL on any stall; STALL->RUN on cycle with no stall; STALL->TIMEOUT when consecutive stall count reaches MAX_STALL; TIMEOUT only left by reset.
REQ-015 Stall counter width $clog2(MAX_STALL+1); increments each stalled cycle, saturates, zeroes on any non-stalled cycle.
REQ-016 In TIMEOUT: stall_timeout=1, retain[all]=1, clear=0, fetch_stall=1, pc_override=0.
REQ-017 Register 0 of NUM_REGS treated as ordinary; no hardwired-zero exemption.

Reset
REQ-018 rst_n low asynchronously: all shadow tags invalid, counter 0, FSM RUN, stall_timeout 0.
REQ-019 During/after reset with idle inputs: retain=0, clear=0, fetch_stall=0, pc_override=0, target=bp_target.
REQ-020 Reset mid-stall or mid-TIMEOUT returns to RUN with no in-flight tags.

Structure
REQ-021 State enum and tag struct {valid, dst} SHALL live in the shared nand_cpu package; `PC_SIZE from nand_cpu.svh.
REQ-022 One sub-module, hazard_scoreboard, SHALL hold shadow tags and RAW compare; FSM, counter and redirect mux stay in the top.

Verification
REQ-023 Bench SHALL cover:
- Reset then idle -> all outputs 0, state RUN.
- Decode writes r3, next cycle decode reads r3 -> retain[0]=1, clear[1]=1, fetch_stall=1 until tag of r3 leaves register 3.
- fb_valid, predict_taken=1, feedback_taken=0, fb_pc=0x10 -> pc_override=1, target=0x11, clear=4'b0011.
- RAW stall plus taken mispredict to 0x40 same cycle -> target=0x40, clear[0..1]=1, fetch_stall=0.
- busy held 15 cycles (MAX_STALL=15) -> stall_timeout=1 at cycle 15, sticky after busy drops; rst_n low clears.
- fb_valid mispredict while busy=1 -> no pc_override until busy falls, then redirect.
